// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter between the CPU and the loader port.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    CPU_OWN,
    HALT_WAIT,
    LD_IDLE,
    LD_WRITE,
    LD_HOLD,
    LD_READ,
    RELEASE
  } arb_state_t;

  localparam int LD_HOLD_CYCLES = 1;

endpackage

// File: rtl/ram_arbiter.sv
// Arbitrates the program/data RAM between the microcode CPU (default owner) and a loader port.
// Loader grants happen only at instruction boundaries; loader writes get a timed pulse plus hold.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int WR_PULSE_CYCLES = 2,
  parameter int MAX_BURST       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_cpuAddr,
  input  logic [DATA_WIDTH-1:0] i_cpuWrData,
  input  logic                  i_cpuWriteEn,
  input  logic                  i_cpuOE,
  input  logic                  i_cpuInstrBoundary,
  output logic                  o_cpuHalt,
  output logic [DATA_WIDTH-1:0] o_cpuRdData,
  input  logic                  i_ldReq,
  output logic                  o_ldGnt,
  input  logic                  i_ldValid,
  output logic                  o_ldReady,
  input  logic                  i_ldWrite,
  input  logic [ADDR_WIDTH-1:0] i_ldAddr,
  input  logic [DATA_WIDTH-1:0] i_ldWrData,
  output logic [DATA_WIDTH-1:0] o_ldRdData,
  output logic                  o_ldRdValid,
  output logic [ADDR_WIDTH-1:0] o_ramAddr,
  output logic [DATA_WIDTH-1:0] o_ramWrData,
  output logic                  o_ramWe,
  output logic                  o_ramOe,
  input  logic [DATA_WIDTH-1:0] i_ramRdData
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int PW = $clog2(WR_PULSE_CYCLES + 1);

  arb_state_t            state_reg, state_next;
  logic [BW-1:0]         burst_reg, burst_next;
  logic [PW-1:0]         pulse_reg, pulse_next;
  logic                  cpu_owed_reg, cpu_owed_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;

  logic burst_full;
  logic accept;
  logic loader_side;

  assign burst_full = (burst_reg == BW'(MAX_BURST));
  // A full burst stops accepting so the grant count never exceeds MAX_BURST.
  assign o_ldReady  = (state_reg == LD_IDLE) && !burst_full;
  assign accept     = i_ldValid && o_ldReady;

  always_comb begin
    state_next    = state_reg;
    burst_next    = burst_reg;
    pulse_next    = pulse_reg;
    cpu_owed_next = cpu_owed_reg;
    case (state_reg)
      CPU_OWN: begin
        if (!i_cpuInstrBoundary) cpu_owed_next = 1'b0;
        if (i_ldReq && !cpu_owed_reg) state_next = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (!i_ldReq)                state_next = CPU_OWN;
        else if (i_cpuInstrBoundary) state_next = LD_IDLE;
      end
      LD_IDLE: begin
        if (accept) begin
          burst_next = burst_reg + BW'(1);
          pulse_next = '0;
          state_next = i_ldWrite ? LD_WRITE : LD_READ;
        end else if (!i_ldReq || burst_full) begin
          state_next = RELEASE;
        end
      end
      LD_WRITE: begin
        if (pulse_reg == PW'(WR_PULSE_CYCLES - 1)) begin
          pulse_next = '0;
          state_next = LD_HOLD;
        end else begin
          pulse_next = pulse_reg + PW'(1);
        end
      end
      LD_HOLD: begin
        if (pulse_reg == PW'(LD_HOLD_CYCLES - 1)) state_next = LD_IDLE;
        else                                       pulse_next = pulse_reg + PW'(1);
      end
      LD_READ: state_next = LD_IDLE;
      RELEASE: begin
        burst_next = '0;
        if (burst_full) cpu_owed_next = 1'b1;
        state_next = CPU_OWN;
      end
      default: state_next = CPU_OWN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg    <= CPU_OWN;
      burst_reg    <= '0;
      pulse_reg    <= '0;
      cpu_owed_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      burst_reg    <= burst_next;
      pulse_reg    <= pulse_next;
      cpu_owed_reg <= cpu_owed_next;
      if (accept) begin
        addr_reg  <= i_ldAddr;
        wdata_reg <= i_ldWrData;
      end
      if (state_reg == LD_READ) rd_data_reg <= i_ramRdData;
      rd_valid_reg <= (state_reg == LD_READ);
    end
  end

  // Everything past HALT_WAIT drives the RAM from the latched loader transfer.
  assign loader_side = (state_reg != CPU_OWN) && (state_reg != HALT_WAIT);

  always_comb begin
    o_ramAddr   = i_cpuAddr;
    o_ramWrData = i_cpuWrData;
    o_ramWe     = i_cpuWriteEn;
    o_ramOe     = i_cpuOE;
    if (loader_side) begin
      o_ramAddr   = addr_reg;
      o_ramWrData = wdata_reg;
      o_ramWe     = (state_reg == LD_WRITE);
      o_ramOe     = (state_reg == LD_READ);
    end
  end

  always_comb begin
    case (state_reg)
      CPU_OWN:   o_cpuHalt = 1'b0;
      HALT_WAIT: o_cpuHalt = i_cpuInstrBoundary;
      default:   o_cpuHalt = 1'b1;
    endcase
  end

  assign o_ldGnt     = (state_reg == LD_IDLE) || (state_reg == LD_WRITE) ||
                       (state_reg == LD_HOLD) || (state_reg == LD_READ);
  assign o_ldRdData  = rd_data_reg;
  assign o_ldRdValid = rd_valid_reg;
  assign o_cpuRdData = i_ramRdData;

endmodule
